// File: rtl/segment_scanner.sv
// Time-multiplexed seven-segment scanner: snapshots a packed segment bus once per frame and drives one digit at a time.
// Latency: outputs are registered and track the scan state with no extra delay; frame period 1 + NumDigits*(BlankCycles+DriveCycles).
// Backpressure: none; free-running scan. Inputs are sampled only in the LOAD cycle.
//
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   segments_i     - byte k = digit k (digit 0 rightmost), bit0..6 = a..g, bit7 = dp, 1 = lit
//   brightness_i   - duty level 0..7 (only with SEGMENT_SCANNER_DIM_EN defined)
//   anode_o        - active-low digit enables, at most one low
//   cathode_o      - active-low segment bus
//   digit_o        - index of the digit currently addressed
//   frame_o        - one-cycle pulse in each LOAD cycle
//
// Optional feature: define SEGMENT_SCANNER_DIM_EN to enable PWM dimming of the
// cathodes within each DRIVE window.

module segment_scanner #(
    parameter int NumDigits   = 8,
    parameter int BlankCycles = 16,
    parameter int DriveCycles = 1024
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic [8*NumDigits-1:0]                              segments_i,
    input  logic [2:0]                                          brightness_i,
    output logic [NumDigits-1:0]                                anode_o,
    output logic [7:0]                                          cathode_o,
    output logic [((NumDigits > 1) ? $clog2(NumDigits) : 1)-1:0] digit_o,
    output logic                                                frame_o
);

    localparam int IdxW   = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam int CntMax = (BlankCycles > DriveCycles) ? BlankCycles : DriveCycles;
    localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [8*NumDigits-1:0] snap_q, snap_d;

    logic [NumDigits-1:0]   anode_d;
    logic [7:0]             cathode_d;
    logic [IdxW-1:0]        digit_d;
    logic                   frame_d;
    logic                   lit_win;

`ifdef SEGMENT_SCANNER_DIM_EN
    logic [2:0]             bright_q, bright_d;
    logic [31:0]            dim_thresh;
`else
    // Brightness has no effect in this build; keep the port but tie it off.
    logic                   unused_brightness;
    assign unused_brightness = ^brightness_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
`ifdef SEGMENT_SCANNER_DIM_EN
            bright_q  <= 3'd7;
`endif
            anode_o   <= '1;
            cathode_o <= 8'hFF;
            digit_o   <= '0;
            frame_o   <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
`ifdef SEGMENT_SCANNER_DIM_EN
            bright_q  <= bright_d;
`endif
            anode_o   <= anode_d;
            cathode_o <= cathode_d;
            digit_o   <= digit_d;
            frame_o   <= frame_d;
        end
    end

    // Next-state logic, then output decode from the *next* state so the
    // output flops show exactly the state the scanner is in this cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
`ifdef SEGMENT_SCANNER_DIM_EN
        bright_d = bright_q;
`endif

        case (state_q)
            ST_LOAD: begin
                snap_d  = segments_i;
`ifdef SEGMENT_SCANNER_DIM_EN
                bright_d = brightness_i;
`endif
                idx_d   = '0;
                cnt_d   = '0;
                state_d = ST_BLANK;
            end
            ST_BLANK: begin
                if (cnt_q == CntW'(BlankCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CntW'(DriveCycles - 1)) begin
                    cnt_d = '0;
                    // idx holds its last value through LOAD; it is cleared on LOAD exit.
                    if (idx_q == IdxW'(NumDigits - 1)) begin
                        state_d = ST_LOAD;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_BLANK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

`ifdef SEGMENT_SCANNER_DIM_EN
        // Lit window is the first floor((bright+1)*DriveCycles/8) cycles of DRIVE.
        dim_thresh = ((32'(bright_d) + 32'd1) * 32'(DriveCycles)) >> 3;
        lit_win    = (32'(cnt_d) < dim_thresh);
`else
        lit_win    = 1'b1;
`endif

        anode_d   = '1;
        cathode_d = 8'hFF;
        digit_d   = idx_d;
        frame_d   = (state_d == ST_LOAD);

        if (state_d == ST_DRIVE) begin
            for (int k = 0; k < NumDigits; k++) begin
                anode_d[k] = (idx_d != IdxW'(k));
            end
            if (lit_win) begin
                cathode_d = ~snap_d[8*idx_d +: 8];
            end
        end
    end

endmodule
